// File: rtl/serial_tx_sched.sv
// Round-robin scheduler sharing one word serializer between two requesters.
// Sequences start/done per word, enforces a guard gap and abandons stalled words.
module serial_tx_sched #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              ser_start,
  output logic [DATA_W-1:0] ser_data,
  input  logic              ser_done,
  output logic              grant_id,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       tx_count
);

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  state_t              r_state;
  logic                r_ser_start;
  logic [DATA_W-1:0]   r_ser_data;
  logic                r_grant_id;
  logic                r_last_grant;
  logic                r_busy;
  logic                r_timeout_err;
  logic [15:0]         r_tx_count;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [GAP_W-1:0]    r_gap_cnt;

  logic w_idle;
  logic w_win1;
  logic w_accept;
  logic w_word_end;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign w_idle     = (r_state == S_IDLE);
  assign w_win1     = req1_valid & (~req0_valid | ~r_last_grant);
  assign req1_ready = w_idle & w_win1;
  assign req0_ready = w_idle & req0_valid & ~w_win1;
  assign w_accept   = req0_ready | req1_ready;
  assign w_word_end = (r_state == S_WAIT) & (ser_done | (r_wait_cnt == WAIT_LAST));

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state       <= S_IDLE;
      r_ser_start   <= 1'b0;
      r_ser_data    <= '0;
      r_grant_id    <= 1'b0;
      r_last_grant  <= 1'b1;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_tx_count    <= '0;
      r_wait_cnt    <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_ser_start   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ser_data  <= w_win1 ? req1_data : req0_data;
            r_grant_id  <= w_win1;
            r_ser_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          // Done wins over a coincident expiry; the word then counts and no error pulses.
          if (w_word_end) begin
            r_last_grant  <= r_grant_id;
            r_tx_count    <= r_tx_count + {15'd0, ser_done};
            r_timeout_err <= ~ser_done;
            r_gap_cnt     <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_start   = r_ser_start;
  assign ser_data    = r_ser_data;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign tx_count    = r_tx_count;

endmodule
